// File: rtl/rc4_decrypt_core.sv
// RC4 decryption engine: S-box init, key scheduling, then keystream XOR of the encrypted ROM into the decrypted RAM.
// Optional macro RC4_CHECK_EN: abort the run at the first plaintext byte outside 'a'..'z' / space.
module rc4_decrypt_core #(
   parameter int KEY_BYTES = 3,
   parameter int MSG_LEN   = 32,
   parameter int MSG_AW    = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [8*KEY_BYTES-1:0] secret_key,
   output logic                   busy,
   output logic                   done,
   output logic                   key_valid,
   output logic [7:0]             s_mem_addr,
   output logic [7:0]             s_mem_data_in,
   output logic                   s_mem_write,
   input  logic [7:0]             s_mem_data_out,
   output logic [MSG_AW-1:0]      e_mem_addr,
   input  logic [7:0]             e_mem_data_out,
   output logic [MSG_AW-1:0]      d_mem_addr,
   output logic [7:0]             d_mem_data_in,
   output logic                   d_mem_write
);

   typedef enum logic [4:0] {
      S_IDLE, S_INIT,
      S_K_RDI, S_K_WTI, S_K_RDJ, S_K_WTJ, S_K_WRI, S_K_WRJ,
      S_P_RDI, S_P_WTI, S_P_RDJ, S_P_WTJ, S_P_WRI, S_P_WRJ, S_P_RDF, S_P_WTF, S_P_OUT,
      S_FINISH
   } state_t;

   localparam logic [3:0]        KEY_LAST = 4'(KEY_BYTES - 1);
   localparam logic [MSG_AW-1:0] MSG_LAST = MSG_AW'(MSG_LEN - 1);

   state_t                 r_state, w_state_n;
   logic [8*KEY_BYTES-1:0] r_key, w_key_n;
   logic [7:0]             r_i, w_i_n, r_j, w_j_n, r_si, w_si_n, r_sj, w_sj_n, r_e, w_e_n;
   logic [3:0]             r_kidx, w_kidx_n;
   logic [MSG_AW-1:0]      r_k, w_k_n;
   logic [7:0]             r_s_addr, w_s_addr_n, r_s_din, w_s_din_n;
   logic                   r_s_we, w_s_we_n;
   logic [MSG_AW-1:0]      r_e_addr, w_e_addr_n, r_d_addr, w_d_addr_n;
   logic [7:0]             r_d_din, w_d_din_n;
   logic                   r_d_we, w_d_we_n;
   logic                   r_busy, w_busy_n, r_done, w_done_n, r_valid, w_valid_n;
   logic [7:0]             w_kb [16];
   logic [7:0]             w_j_ksa, w_j_prga, w_fout;
   logic                   w_ok;

   // Key bytes laid out MSB-first; unused slots read as zero.
   for (genvar b = 0; b < 16; b++) begin : g_kb
      if (b < KEY_BYTES) begin : g_on
         assign w_kb[b] = r_key[8*(KEY_BYTES-1-b) +: 8];
      end else begin : g_off
         assign w_kb[b] = '0;
      end
   end

   assign w_j_ksa  = r_j + s_mem_data_out + w_kb[r_kidx];
   assign w_j_prga = r_j + s_mem_data_out;
   assign w_fout   = s_mem_data_out ^ r_e;

`ifdef RC4_CHECK_EN
   assign w_ok = ((w_fout >= 8'h61) && (w_fout <= 8'h7A)) || (w_fout == 8'h20);
`else
   assign w_ok = 1'b1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_key    <= '0;
         r_i      <= '0;
         r_j      <= '0;
         r_si     <= '0;
         r_sj     <= '0;
         r_e      <= '0;
         r_kidx   <= '0;
         r_k      <= '0;
         r_s_addr <= '0;
         r_s_din  <= '0;
         r_s_we   <= 1'b0;
         r_e_addr <= '0;
         r_d_addr <= '0;
         r_d_din  <= '0;
         r_d_we   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_valid  <= 1'b0;
      end else begin
         r_state  <= w_state_n;
         r_key    <= w_key_n;
         r_i      <= w_i_n;
         r_j      <= w_j_n;
         r_si     <= w_si_n;
         r_sj     <= w_sj_n;
         r_e      <= w_e_n;
         r_kidx   <= w_kidx_n;
         r_k      <= w_k_n;
         r_s_addr <= w_s_addr_n;
         r_s_din  <= w_s_din_n;
         r_s_we   <= w_s_we_n;
         r_e_addr <= w_e_addr_n;
         r_d_addr <= w_d_addr_n;
         r_d_din  <= w_d_din_n;
         r_d_we   <= w_d_we_n;
         r_busy   <= w_busy_n;
         r_done   <= w_done_n;
         r_valid  <= w_valid_n;
      end
   end

   // Reads are issued one state, waited one state, consumed the next (sync RAM latency).
   always_comb begin
      w_state_n  = r_state;
      w_key_n    = r_key;
      w_i_n      = r_i;
      w_j_n      = r_j;
      w_si_n     = r_si;
      w_sj_n     = r_sj;
      w_e_n      = r_e;
      w_kidx_n   = r_kidx;
      w_k_n      = r_k;
      w_s_addr_n = r_s_addr;
      w_s_din_n  = r_s_din;
      w_s_we_n   = 1'b0;
      w_e_addr_n = r_e_addr;
      w_d_addr_n = r_d_addr;
      w_d_din_n  = r_d_din;
      w_d_we_n   = 1'b0;
      w_busy_n   = r_busy;
      w_done_n   = r_done;
      w_valid_n  = r_valid;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_key_n   = secret_key;
               w_done_n  = 1'b0;
               w_valid_n = 1'b0;
               w_busy_n  = 1'b1;
               w_i_n     = '0;
               w_state_n = S_INIT;
            end
         end
         S_INIT: begin
            w_s_addr_n = r_i;
            w_s_din_n  = r_i;
            w_s_we_n   = 1'b1;
            w_i_n      = r_i + 8'd1;
            if (r_i == 8'hFF) begin
               w_j_n     = '0;
               w_kidx_n  = '0;
               w_state_n = S_K_RDI;
            end
         end
         S_K_RDI: begin
            w_s_addr_n = r_i;
            w_state_n  = S_K_WTI;
         end
         S_K_WTI: w_state_n = S_K_RDJ;
         S_K_RDJ: begin
            w_si_n     = s_mem_data_out;
            w_j_n      = w_j_ksa;
            w_s_addr_n = w_j_ksa;
            w_state_n  = S_K_WTJ;
         end
         S_K_WTJ: w_state_n = S_K_WRI;
         S_K_WRI: begin
            w_s_addr_n = r_i;
            w_s_din_n  = s_mem_data_out;
            w_s_we_n   = 1'b1;
            w_state_n  = S_K_WRJ;
         end
         S_K_WRJ: begin
            w_s_addr_n = r_j;
            w_s_din_n  = r_si;
            w_s_we_n   = 1'b1;
            w_i_n      = r_i + 8'd1;
            w_kidx_n   = (r_kidx == KEY_LAST) ? 4'd0 : r_kidx + 4'd1;
            if (r_i == 8'hFF) begin
               w_j_n     = '0;
               w_k_n     = '0;
               w_state_n = S_P_RDI;
            end else begin
               w_state_n = S_K_RDI;
            end
         end
         S_P_RDI: begin
            w_i_n      = r_i + 8'd1;
            w_s_addr_n = r_i + 8'd1;
            w_e_addr_n = r_k;
            w_state_n  = S_P_WTI;
         end
         S_P_WTI: w_state_n = S_P_RDJ;
         S_P_RDJ: begin
            w_si_n     = s_mem_data_out;
            w_j_n      = w_j_prga;
            w_s_addr_n = w_j_prga;
            w_e_n      = e_mem_data_out;
            w_state_n  = S_P_WTJ;
         end
         S_P_WTJ: w_state_n = S_P_WRI;
         S_P_WRI: begin
            w_sj_n     = s_mem_data_out;
            w_s_addr_n = r_i;
            w_s_din_n  = s_mem_data_out;
            w_s_we_n   = 1'b1;
            w_state_n  = S_P_WRJ;
         end
         S_P_WRJ: begin
            w_s_addr_n = r_j;
            w_s_din_n  = r_si;
            w_s_we_n   = 1'b1;
            w_state_n  = S_P_RDF;
         end
         S_P_RDF: begin
            w_s_addr_n = r_si + r_sj;
            w_state_n  = S_P_WTF;
         end
         S_P_WTF: w_state_n = S_P_OUT;
         S_P_OUT: begin
            w_d_addr_n = r_k;
            w_d_din_n  = w_fout;
            w_d_we_n   = 1'b1;
            w_k_n      = r_k + 1'b1;
            if (!w_ok || (r_k == MSG_LAST)) begin
               w_valid_n = w_ok;
               w_state_n = S_FINISH;
            end else begin
               w_state_n = S_P_RDI;
            end
         end
         S_FINISH: begin
            w_busy_n  = 1'b0;
            w_done_n  = 1'b1;
            w_state_n = S_IDLE;
         end
         default: w_state_n = S_IDLE;
      endcase
   end

   assign busy          = r_busy;
   assign done          = r_done;
   assign key_valid     = r_valid;
   assign s_mem_addr    = r_s_addr;
   assign s_mem_data_in = r_s_din;
   assign s_mem_write   = r_s_we;
   assign e_mem_addr    = r_e_addr;
   assign d_mem_addr    = r_d_addr;
   assign d_mem_data_in = r_d_din;
   assign d_mem_write   = r_d_we;

endmodule
